// File: rtl/demux12_2b_valid.sv
// 1:2 valid demultiplexer: routes one input word to one of two registered lanes,
// chosen by an external select or by an internal round-robin pointer, and counts the words on each lane.
module demux12_2b_valid #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             select,
    input  logic             mode,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             out0_valid,
    output logic             out1_valid,
    output logic             rr_sel,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1
);

    logic sel;

    // The pointer value from the current cycle is used, so the pointer only advances after routing.
    assign sel = mode ? rr_sel : select;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out0       <= '0;
            out1       <= '0;
            out0_valid <= 1'b0;
            out1_valid <= 1'b0;
            rr_sel     <= 1'b0;
            count0     <= '0;
            count1     <= '0;
        end else begin
            // NOTE: both valids are cleared by default, so a valid lasts one cycle unless a new word refreshes it.
            out0_valid <= 1'b0;
            out1_valid <= 1'b0;
            if (in_valid) begin
                if (sel) begin
                    out1       <= in;
                    out1_valid <= 1'b1;
                    count1     <= count1 + CNT_W'(1);
                end else begin
                    out0       <= in;
                    out0_valid <= 1'b1;
                    count0     <= count0 + CNT_W'(1);
                end
                if (mode) begin
                    rr_sel <= ~rr_sel;
                end
            end
        end
    end

endmodule
